// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - pipelined add/sub/and/xor unit with per-stage valid/ready flow control
// Optional ALU_PIPE_SAT_EN: clamp overflowing add/sub results to signed saturation.
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res0;
  logic             cout0;
  logic             ovf0;

  // Bit WIDTH of the WIDTH+1 difference is the borrow, since b + cin never exceeds 2^WIDTH.
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    diff  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    res0  = '0;
    cout0 = 1'b0;
    ovf0  = 1'b0;
    case (op)
      2'b00: begin
        res0  = sum[WIDTH-1:0];
        cout0 = sum[WIDTH];
        ovf0  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      2'b01: begin
        res0  = diff[WIDTH-1:0];
        cout0 = diff[WIDTH];
        ovf0  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      2'b10: res0 = a & b;
      2'b11: res0 = a ^ b;
      default: res0 = '0;
    endcase
`ifdef ALU_PIPE_SAT_EN
    if (ovf0) begin
      res0 = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  logic [STAGES:1]   valid_q, valid_d;
  logic [STAGES:1]   cout_q, cout_d;
  logic [STAGES:1]   ovf_q, ovf_d;
  logic [WIDTH-1:0]  r_q   [1:STAGES];
  logic [WIDTH-1:0]  r_d   [1:STAGES];
  logic [STAGES+1:1] ready;
  logic [STAGES:1]   src_v, src_c, src_o;
  logic [WIDTH-1:0]  src_r [1:STAGES];

  for (genvar k = 1; k <= STAGES; k++) begin : g_src
    if (k == 1) begin : g_first
      assign src_v[k] = in_valid;
      assign src_r[k] = res0;
      assign src_c[k] = cout0;
      assign src_o[k] = ovf0;
    end else begin : g_next
      assign src_v[k] = valid_q[k-1];
      assign src_r[k] = r_q[k-1];
      assign src_c[k] = cout_q[k-1];
      assign src_o[k] = ovf_q[k-1];
    end
  end

  always_comb begin
    ready             = '0;
    ready[STAGES+1]   = out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      ready[k] = !valid_q[k] | ready[k+1];
    end
  end

  // Payload only moves with a valid beat so bubbles leave held data untouched.
  always_comb begin
    valid_d = valid_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    r_d     = r_q;
    for (int k = 1; k <= STAGES; k++) begin
      if (ready[k]) begin
        valid_d[k] = src_v[k];
        if (src_v[k]) begin
          r_d[k]    = src_r[k];
          cout_d[k] = src_c[k];
          ovf_d[k]  = src_o[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      cout_q  <= '0;
      ovf_q   <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        r_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      r_q     <= r_d;
    end
  end

  assign in_ready  = ready[1] & rst_n;
  assign out_valid = valid_q[STAGES];
  assign r         = r_q[STAGES];
  assign cout      = cout_q[STAGES];
  assign ovf       = ovf_q[STAGES];

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe at default WIDTH=32, STAGES=3
module tb_alu_pipe;
  localparam int W = 32;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] r;

  alu_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .r(r), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [W+1:0]  sb[$];
  int            sb_t[$];
  bit            lat_chk = 0;
  bit            occ_chk = 0;
  bit            acc = 0;
  bit            use_exp = 0;
  logic [W+1:0]  exp_val = '0;
  bit            held_v = 0;
  logic [W-1:0]  held_r = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: flags derived from wide signed/unsigned arithmetic rather than sign-bit rules.
  function automatic logic [W+1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic c);
    longint sx, sy, sres, smax, smin;
    logic [W:0]   u;
    logic [W-1:0] res;
    logic         co, ov;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    sres = 0;
    co   = 1'b0;
    ov   = 1'b0;
    case (o)
      2'b00: begin
        u    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        res  = u[W-1:0];
        co   = u[W];
        sres = sx + sy + longint'(c);
      end
      2'b01: begin
        res  = x - y - {{(W-1){1'b0}}, c};
        co   = ({1'b0, x} < ({1'b0, y} + {{W{1'b0}}, c}));
        sres = sx - sy - longint'(c);
      end
      2'b10: res = x & y;
      default: res = x ^ y;
    endcase
    if (o[1] == 1'b0) ov = (sres > smax) || (sres < smin);
`ifdef ALU_PIPE_SAT_EN
    if (ov) res = (sres > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    return {co, ov, res};
  endfunction

  task automatic cycle();
    logic [W+1:0] e;
    int t;
    #1;
    acc = in_valid && in_ready;
    if (occ_chk) check_eq("in_ready_occ", in_ready, (sb.size() < S) || out_ready);
    if (held_v && rst_n) begin
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_r", r, held_r);
    end
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out", out_valid, 0);
      end else begin
        e = sb.pop_front();
        t = sb_t.pop_front();
        check_eq("result", {cout, ovf, r}, e);
        if (lat_chk) check_eq("latency", cyc - t, S);
      end
    end
    held_v = rst_n && out_valid && !out_ready;
    held_r = r;
    if (acc) begin
      sb.push_back(use_exp ? exp_val : model(op, a, b, cin));
      sb_t.push_back(cyc);
    end
    @(posedge clk);
    if (!rst_n) begin
      sb.delete();
      sb_t.delete();
      held_v = 0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input bit pat);
    int k;
    k = 0;
    in_valid = 1'b0;
    while (sb.size() > 0 && k < 100) begin
      out_ready = pat ? (k % 3 == 0) : 1'b1;
      cycle();
      k++;
    end
    check_eq("drain_empty", sb.size(), 0);
  endtask

  task automatic send_exp(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic [W+1:0] ev);
    in_valid = 1'b1; op = o; a = x; b = y; cin = c;
    use_exp = 1; exp_val = ev;
    cycle();
    check_eq("directed_accept", acc, 1);
    use_exp = 0;
    in_valid = 1'b0;
  endtask

  initial begin
    int i, k;
    @(negedge clk);

    rst_n = 1'b0; in_valid = 1'b1; a = 32'd1; b = 32'd2;
    repeat (3) cycle();
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_r", r, 0);
    check_eq("rst_cout", cout, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_in_ready", in_ready, 0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    check_eq("rel_in_ready", in_ready, 1);

    lat_chk = 1; out_ready = 1'b1;
    send_exp(2'b00, 32'd5, 32'd7, 1'b1, {1'b0, 1'b0, 32'd13});
    drain(0);

    send_exp(2'b00, 32'hFFFF_FFFF, 32'd1, 1'b0, {1'b1, 1'b0, 32'h0000_0000});
`ifdef ALU_PIPE_SAT_EN
    send_exp(2'b00, 32'h7FFF_FFFF, 32'd1, 1'b0, {1'b0, 1'b1, 32'h7FFF_FFFF});
`else
    send_exp(2'b00, 32'h7FFF_FFFF, 32'd1, 1'b0, {1'b0, 1'b1, 32'h8000_0000});
`endif
    send_exp(2'b01, 32'd3, 32'd5, 1'b0, {1'b1, 1'b0, 32'hFFFF_FFFE});
    drain(0);

    lat_chk = 0; occ_chk = 1;
    i = 0; k = 0;
    while (i < 10 && k < 200) begin
      out_ready = (k % 3 == 0);
      in_valid = 1'b1; op = 2'b00; a = i; b = '0; cin = 1'b0;
      cycle();
      if (acc) i++;
      k++;
    end
    check_eq("bp_all_sent", i, 10);
    drain(1);
    occ_chk = 0;

    lat_chk = 1; out_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      in_valid = 1'b1;
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      cycle();
      check_eq("thru_accept", acc, 1);
    end
    drain(0);

    lat_chk = 0;
    in_valid = 1'b1; op = 2'b00; a = 32'd100; b = 32'd1; cin = 1'b0;
    cycle();
    a = 32'd200;
    cycle();
    in_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (6) cycle();
    lat_chk = 1;
    send_exp(2'b11, 32'hF0F0_0000, 32'h0FF0_0001, 1'b1, {1'b0, 1'b0, 32'hFF00_0001});
    drain(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
